// File: rtl/dtbdm_frame_sequencer_if.sv
// Signal bundle between the DTBDM frame sequencer, the video source and the denoise core.
// The sequencer connects through the slave modport; the source/core side uses master.
interface dtbdm_frame_sequencer_if #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          iStart;
  logic          iPixValid;
  logic [7:0]    iv8Pixel;
  logic          oPixReady;

  logic          oDataValid;
  logic [7:0]    ov8Pixel_a;
  logic [7:0]    ov8Pixel_b;
  logic [7:0]    ov8Pixel_c;
  logic [7:0]    ov8Pixel_d;
  logic [7:0]    ov8Pixel_e;
  logic [7:0]    ov8Pixel_f;
  logic [7:0]    ov8Pixel_g;
  logic [7:0]    ov8Pixel_h;
  logic [7:0]    ov8Pixel_fij;

  logic          iCoreValid;
  logic [7:0]    iv8CorePixel;

  logic          oOutValid;
  logic [7:0]    ov8OutPixel;
  logic [RW-1:0] ovOutRow;
  logic [CW-1:0] ovOutCol;
  logic          oBusy;
  logic          oFrameDone;

  modport slave (
    input  iStart, iPixValid, iv8Pixel, iCoreValid, iv8CorePixel,
    output oPixReady, oDataValid,
    output ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d,
    output ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h, ov8Pixel_fij,
    output oOutValid, ov8OutPixel, ovOutRow, ovOutCol, oBusy, oFrameDone
  );

  modport master (
    output iStart, iPixValid, iv8Pixel, iCoreValid, iv8CorePixel,
    input  oPixReady, oDataValid,
    input  ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d,
    input  ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h, ov8Pixel_fij,
    input  oOutValid, ov8OutPixel, ovOutRow, ovOutCol, oBusy, oFrameDone
  );
endinterface

// File: rtl/dtbdm_frame_sequencer.sv
// Frame sequencer for the DTBDM denoise core: buffers rows in three slots, issues clamped
// 3x3 windows one per cycle, and tags returning core results with their (row,col).
module dtbdm_frame_sequencer #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                      iClk,
  input  logic                      iRst,
  dtbdm_frame_sequencer_if.slave    bus
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int NW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
  localparam logic [RW-1:0] PENULT_ROW = RW'(IMG_H - 2);
  localparam logic [NW-1:0] TOTAL_N    = NW'(TOTAL);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [7:0]    r_mem [0:2][0:IMG_W-1];

  logic [CW-1:0] r_wrCol;
  logic [RW-1:0] r_wrRow;
  logic [1:0]    r_wrSlot;
  logic          r_allRcvd;

  logic [CW-1:0] r_issCol;
  logic [RW-1:0] r_issRow;
  logic [1:0]    r_issSlot;

  logic [1:0]    w_slotUp;
  logic [1:0]    w_slotDn;
  logic [CW-1:0] w_colL;
  logic [CW-1:0] w_colR;

  logic          r_dataValid;
  logic [7:0]    r_pixA;
  logic [7:0]    r_pixB;
  logic [7:0]    r_pixC;
  logic [7:0]    r_pixD;
  logic [7:0]    r_pixE;
  logic [7:0]    r_pixF;
  logic [7:0]    r_pixG;
  logic [7:0]    r_pixH;
  logic [7:0]    r_pixFij;

  logic [NW-1:0] r_resCount;
  logic [RW-1:0] r_cntRow;
  logic [CW-1:0] r_cntCol;
  logic          r_outValid;
  logic [7:0]    r_outPixel;
  logic [RW-1:0] r_outRow;
  logic [CW-1:0] r_outCol;

  logic          w_pixReady;
  logic          w_busy;
  logic          w_frameDone;
  logic          w_accept;
  logic          w_frameStart;
  logic          w_countEn;
  logic          w_counting;

  function automatic logic [1:0] slotInc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slotDec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  assign w_accept     = bus.iPixValid && (r_state == RECV);
  assign w_frameStart = bus.iStart && (r_state == IDLE);
  assign w_counting   = (r_state == RECV) || (r_state == ISSUE) || (r_state == DRAIN);
  assign w_countEn    = bus.iCoreValid && w_counting && (r_resCount != TOTAL_N);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.iStart) w_nextState = RECV;
      end
      RECV: begin
        // Row 0 alone cannot form a window; wait for row 1 before issuing.
        if (w_accept && (r_wrCol == LAST_COL)) begin
          w_nextState = (r_wrRow == '0) ? RECV : ISSUE;
        end
      end
      ISSUE: begin
        if (r_issCol == LAST_COL) begin
          if (!r_allRcvd)                   w_nextState = RECV;
          else if (r_issRow == PENULT_ROW)  w_nextState = ISSUE;
          else                              w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (r_resCount == TOTAL_N) w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_pixReady  = 1'b0;
    w_busy      = 1'b1;
    w_frameDone = 1'b0;
    case (r_state)
      IDLE:    w_busy      = 1'b0;
      RECV:    w_pixReady  = 1'b1;
      DONE:    w_frameDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wrCol   <= '0;
      r_wrRow   <= '0;
      r_wrSlot  <= 2'd0;
      r_allRcvd <= 1'b0;
    end else if (w_frameStart) begin
      r_wrCol   <= '0;
      r_wrRow   <= '0;
      r_wrSlot  <= 2'd0;
      r_allRcvd <= 1'b0;
    end else if (w_accept) begin
      if (r_wrCol == LAST_COL) begin
        r_wrCol  <= '0;
        r_wrRow  <= r_wrRow + RW'(1);
        r_wrSlot <= slotInc(r_wrSlot);
        if (r_wrRow == LAST_ROW) r_allRcvd <= 1'b1;
      end else begin
        r_wrCol <= r_wrCol + CW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (w_accept) begin
      r_mem[r_wrSlot][r_wrCol] <= bus.iv8Pixel;
    end
  end

  // Rows are issued strictly in order, so the issue row/slot simply advance per pass.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_issCol  <= '0;
      r_issRow  <= '0;
      r_issSlot <= 2'd0;
    end else if (w_frameStart) begin
      r_issCol  <= '0;
      r_issRow  <= '0;
      r_issSlot <= 2'd0;
    end else if (r_state == ISSUE) begin
      if (r_issCol == LAST_COL) begin
        r_issCol  <= '0;
        r_issRow  <= r_issRow + RW'(1);
        r_issSlot <= slotInc(r_issSlot);
      end else begin
        r_issCol <= r_issCol + CW'(1);
      end
    end
  end

  // Edge replication: out-of-frame neighbours fold back onto the nearest edge row/column.
  always_comb begin
    w_slotUp = (r_issRow == '0)       ? r_issSlot : slotDec(r_issSlot);
    w_slotDn = (r_issRow == LAST_ROW) ? r_issSlot : slotInc(r_issSlot);
    w_colL   = (r_issCol == '0)       ? r_issCol  : r_issCol - CW'(1);
    w_colR   = (r_issCol == LAST_COL) ? r_issCol  : r_issCol + CW'(1);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_dataValid <= 1'b0;
      r_pixA      <= '0;
      r_pixB      <= '0;
      r_pixC      <= '0;
      r_pixD      <= '0;
      r_pixE      <= '0;
      r_pixF      <= '0;
      r_pixG      <= '0;
      r_pixH      <= '0;
      r_pixFij    <= '0;
    end else begin
      r_dataValid <= (r_state == ISSUE);
      if (r_state == ISSUE) begin
        r_pixA   <= r_mem[w_slotUp][w_colL];
        r_pixB   <= r_mem[w_slotUp][r_issCol];
        r_pixC   <= r_mem[w_slotUp][w_colR];
        r_pixD   <= r_mem[r_issSlot][w_colL];
        r_pixFij <= r_mem[r_issSlot][r_issCol];
        r_pixE   <= r_mem[r_issSlot][w_colR];
        r_pixF   <= r_mem[w_slotDn][w_colL];
        r_pixG   <= r_mem[w_slotDn][r_issCol];
        r_pixH   <= r_mem[w_slotDn][w_colR];
      end
    end
  end

  // Results come back in issue order, so a raster counter is enough to tag them.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_resCount <= '0;
      r_cntRow   <= '0;
      r_cntCol   <= '0;
      r_outValid <= 1'b0;
      r_outPixel <= '0;
      r_outRow   <= '0;
      r_outCol   <= '0;
    end else begin
      r_outValid <= w_countEn;
      if (w_frameStart) begin
        r_resCount <= '0;
        r_cntRow   <= '0;
        r_cntCol   <= '0;
      end else if (w_countEn) begin
        r_outPixel <= bus.iv8CorePixel;
        r_outRow   <= r_cntRow;
        r_outCol   <= r_cntCol;
        r_resCount <= r_resCount + NW'(1);
        if (r_cntCol == LAST_COL) begin
          r_cntCol <= '0;
          r_cntRow <= r_cntRow + RW'(1);
        end else begin
          r_cntCol <= r_cntCol + CW'(1);
        end
      end
    end
  end

  assign bus.oPixReady    = w_pixReady;
  assign bus.oBusy        = w_busy;
  assign bus.oFrameDone   = w_frameDone;
  assign bus.oDataValid   = r_dataValid;
  assign bus.ov8Pixel_a   = r_pixA;
  assign bus.ov8Pixel_b   = r_pixB;
  assign bus.ov8Pixel_c   = r_pixC;
  assign bus.ov8Pixel_d   = r_pixD;
  assign bus.ov8Pixel_e   = r_pixE;
  assign bus.ov8Pixel_f   = r_pixF;
  assign bus.ov8Pixel_g   = r_pixG;
  assign bus.ov8Pixel_h   = r_pixH;
  assign bus.ov8Pixel_fij = r_pixFij;
  assign bus.oOutValid    = r_outValid;
  assign bus.ov8OutPixel  = r_outPixel;
  assign bus.ovOutRow     = r_outRow;
  assign bus.ovOutCol     = r_outCol;
endmodule
